// File: rtl/amb_yurut_denetleyici.sv
// Execute-stage sequencer for the ALU/MUL/DIV unit: accepts one decoded op, drives the unit
// enable for the op's latency, then holds the result until the memory stage takes it.
// Op codes: ADD 0..SLTU 9 (1 cycle), MUL group 10..13, DIV/REM group 14..17, JAL 18, JALR 19.
module amb_yurut_denetleyici #(
  parameter int unsigned CARPMA_GECIKME  = 3,
  parameter int unsigned BOLME_GECIKME   = 33,
  parameter int unsigned SAYAC_GENISLIGI = 6
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       buyruk_gecerli_i,
  input  logic [5:0] islem_kodu_i,
  output logic       buyruk_hazir_o,
  output logic       durdur_o,
  output logic       amb_aktif_o,
  output logic [5:0] amb_islem_kodu_o,
  input  logic       amb_hazir_i,
  output logic       sonuc_gecerli_o,
  input  logic       sonraki_hazir_i,
  output logic       dallanma_o,
  input  logic       temizle_i
);

  localparam logic [5:0] AluMul    = 6'd10;
  localparam logic [5:0] AluMulh   = 6'd11;
  localparam logic [5:0] AluMulhsu = 6'd12;
  localparam logic [5:0] AluMulhu  = 6'd13;
  localparam logic [5:0] AluDiv    = 6'd14;
  localparam logic [5:0] AluDivu   = 6'd15;
  localparam logic [5:0] AluRem    = 6'd16;
  localparam logic [5:0] AluRemu   = 6'd17;
  localparam logic [5:0] AluJal    = 6'd18;
  localparam logic [5:0] AluJalr   = 6'd19;

  localparam int unsigned CarpmaL = (CARPMA_GECIKME == 0) ? 1 : CARPMA_GECIKME;
  localparam int unsigned BolmeL  = (BOLME_GECIKME == 0) ? 1 : BOLME_GECIKME;

  typedef enum logic [1:0] {StBosta, StYurut, StSonuc} durum_e;

  durum_e                     durum_q, durum_d;
  logic [SAYAC_GENISLIGI-1:0] sayac_q, sayac_d;
  logic [5:0]                 islem_q, islem_d;
  logic                       dallanma_q, dallanma_d;
  logic                       kabul;

  // Counter load value is latency-1 so the last enable cycle sees a zero count.
  function automatic logic [SAYAC_GENISLIGI-1:0] gecikme_eksi1(input logic [5:0] kod);
    int unsigned l;
    case (kod)
      AluMul, AluMulh, AluMulhsu, AluMulhu: l = CarpmaL;
      AluDiv, AluDivu, AluRem, AluRemu:     l = BolmeL;
      default:                              l = 1;
    endcase
    return SAYAC_GENISLIGI'(l - 1);
  endfunction

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      durum_q    <= StBosta;
      sayac_q    <= '0;
      islem_q    <= '0;
      dallanma_q <= 1'b0;
    end else begin
      durum_q    <= durum_d;
      sayac_q    <= sayac_d;
      islem_q    <= islem_d;
      dallanma_q <= dallanma_d;
    end
  end

  assign kabul = buyruk_gecerli_i & buyruk_hazir_o & ~temizle_i;

  always_comb begin
    durum_d    = durum_q;
    sayac_d    = sayac_q;
    islem_d    = islem_q;
    dallanma_d = 1'b0;
    if (temizle_i) begin
      durum_d = StBosta;
      sayac_d = '0;
    end else begin
      unique case (durum_q)
        StBosta: begin
          if (kabul) begin
            durum_d = StYurut;
            islem_d = islem_kodu_i;
            sayac_d = gecikme_eksi1(islem_kodu_i);
          end
        end
        StYurut: begin
          if (sayac_q != '0) begin
            sayac_d = sayac_q - 1'b1;
          end else if (amb_hazir_i) begin
            durum_d = StSonuc;
          end
        end
        StSonuc: begin
          if (sonraki_hazir_i) begin
            dallanma_d = (islem_q == AluJal) || (islem_q == AluJalr);
            if (kabul) begin
              durum_d = StYurut;
              islem_d = islem_kodu_i;
              sayac_d = gecikme_eksi1(islem_kodu_i);
            end else begin
              durum_d = StBosta;
            end
          end
        end
        default: durum_d = StBosta;
      endcase
    end
  end

  always_comb begin
    buyruk_hazir_o  = 1'b0;
    amb_aktif_o     = 1'b0;
    sonuc_gecerli_o = 1'b0;
    unique case (durum_q)
      StBosta: buyruk_hazir_o = 1'b1;
      StYurut: amb_aktif_o = 1'b1;
      StSonuc: begin
        sonuc_gecerli_o = 1'b1;
        buyruk_hazir_o  = sonraki_hazir_i;
      end
      default: buyruk_hazir_o = 1'b0;
    endcase
  end

  assign durdur_o         = buyruk_gecerli_i & ~buyruk_hazir_o;
  assign amb_islem_kodu_o = islem_q;
  assign dallanma_o       = dallanma_q;

endmodule

// File: tb/tb_amb_yurut_denetleyici.sv
// Bench for amb_yurut_denetleyici: directed scenarios plus random traffic, checked by a
// transaction scoreboard (queue of accepted ops) against an op-level latency model.
module tb_amb_yurut_denetleyici;

  localparam int unsigned CarpmaG = 3;
  localparam int unsigned BolmeG  = 33;

  localparam logic [5:0] OpAdd = 6'd0;
  localparam logic [5:0] OpMul = 6'd10;
  localparam logic [5:0] OpDiv = 6'd14;
  localparam logic [5:0] OpRem = 6'd16;
  localparam logic [5:0] OpJal = 6'd18;

  logic       clk_i = 1'b0;
  logic       rst_ni = 1'b0;
  logic       buyruk_gecerli_i = 1'b0;
  logic [5:0] islem_kodu_i = '0;
  logic       buyruk_hazir_o, durdur_o, amb_aktif_o, sonuc_gecerli_o, dallanma_o;
  logic [5:0] amb_islem_kodu_o;
  logic       amb_hazir_i = 1'b1;
  logic       sonraki_hazir_i = 1'b1;
  logic       temizle_i = 1'b0;

  int n_tot = 0;
  int n_pass = 0;

  always #5 clk_i = ~clk_i;

  amb_yurut_denetleyici #(
    .CARPMA_GECIKME (CarpmaG),
    .BOLME_GECIKME  (BolmeG),
    .SAYAC_GENISLIGI(6)
  ) dut (
    .clk_i           (clk_i),
    .rst_ni          (rst_ni),
    .buyruk_gecerli_i(buyruk_gecerli_i),
    .islem_kodu_i    (islem_kodu_i),
    .buyruk_hazir_o  (buyruk_hazir_o),
    .durdur_o        (durdur_o),
    .amb_aktif_o     (amb_aktif_o),
    .amb_islem_kodu_o(amb_islem_kodu_o),
    .amb_hazir_i     (amb_hazir_i),
    .sonuc_gecerli_o (sonuc_gecerli_o),
    .sonraki_hazir_i (sonraki_hazir_i),
    .dallanma_o      (dallanma_o),
    .temizle_i       (temizle_i)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
  endtask

  // Latency from the op-group rules.
  function automatic int lat_of(input logic [5:0] op);
    if (op >= 6'd10 && op <= 6'd13) return (CarpmaG == 0) ? 1 : CarpmaG;
    if (op >= 6'd14 && op <= 6'd17) return (BolmeG == 0) ? 1 : BolmeG;
    return 1;
  endfunction

  typedef struct {
    logic [5:0] op;
    int         lat;
  } islem_t;

  islem_t exp_q[$];
  bit     in_result = 0;
  int     n_aktif = 0;
  bit     exp_dal = 0;

  // Monitor: compares present outputs with the model, then advances the model to the next edge.
  always @(negedge clk_i) begin : mon
    bit has, hz_exp, acc;
    islem_t yeni;
    if (!rst_ni) begin
      exp_q.delete();
      in_result = 0;
      n_aktif   = 0;
      exp_dal   = 0;
    end else begin
      has    = exp_q.size() != 0;
      hz_exp = !has || (in_result && sonraki_hazir_i);
      chk("amb_aktif", 32'(amb_aktif_o), 32'(has && !in_result));
      chk("sonuc_gecerli", 32'(sonuc_gecerli_o), 32'(has && in_result));
      chk("buyruk_hazir", 32'(buyruk_hazir_o), 32'(hz_exp));
      chk("durdur", 32'(durdur_o), 32'(buyruk_gecerli_i && !hz_exp));
      chk("dallanma", 32'(dallanma_o), 32'(exp_dal));
      if (has) chk("amb_islem_kodu", 32'(amb_islem_kodu_o), 32'(exp_q[0].op));
      exp_dal = 0;
      if (temizle_i) begin
        exp_q.delete();
        in_result = 0;
        n_aktif   = 0;
      end else begin
        acc = buyruk_gecerli_i && hz_exp;
        if (has && !in_result) begin
          n_aktif++;
          if (n_aktif >= exp_q[0].lat && amb_hazir_i) in_result = 1;
        end else if (has && sonraki_hazir_i) begin
          exp_dal = (exp_q[0].op == 6'd18) || (exp_q[0].op == 6'd19);
          void'(exp_q.pop_front());
          in_result = 0;
          n_aktif   = 0;
        end
        if (acc) begin
          yeni.op  = islem_kodu_i;
          yeni.lat = lat_of(islem_kodu_i);
          exp_q.push_back(yeni);
        end
      end
    end
  end

  task automatic step(input bit v, input logic [5:0] op, input bit ah, input bit sh,
                      input bit tz);
    buyruk_gecerli_i = v;
    islem_kodu_i     = op;
    amb_hazir_i      = ah;
    sonraki_hazir_i  = sh;
    temizle_i        = tz;
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle(input int n, input bit ah, input bit sh);
    for (int i = 0; i < n; i++) step(1'b0, OpAdd, ah, sh, 1'b0);
  endtask

  initial begin
    logic [5:0] rop;
    int         r;
    #2;
    chk("reset_hazir", 32'(buyruk_hazir_o), 32'd1);
    chk("reset_aktif", 32'(amb_aktif_o), 32'd0);
    chk("reset_gecerli", 32'(sonuc_gecerli_o), 32'd0);
    chk("reset_kod", 32'(amb_islem_kodu_o), 32'd0);
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    idle(2, 1, 1);

    // Single-cycle op, then a long divide with decode valid throughout.
    step(1, OpAdd, 1, 1, 0);
    idle(3, 1, 1);
    step(1, OpDiv, 1, 1, 0);
    for (int i = 0; i < 36; i++) step(1, OpAdd, 1, 1, 0);
    idle(3, 1, 1);

    // Result held while memory stage stalls.
    step(1, OpAdd, 1, 0, 0);
    idle(6, 1, 0);
    idle(2, 1, 1);

    // Back-to-back ADD then MUL.
    step(1, OpAdd, 1, 1, 0);
    step(1, OpMul, 1, 1, 0);
    step(1, OpMul, 1, 1, 0);
    idle(5, 1, 1);

    // Flush in the middle of a remainder, with a concurrent valid.
    step(1, OpRem, 1, 1, 0);
    idle(8, 1, 1);
    step(1, OpAdd, 1, 1, 1);
    idle(3, 1, 1);

    // Jump handoff, and a unit that is late with its ready.
    step(1, OpJal, 1, 1, 0);
    idle(3, 1, 1);
    step(1, OpMul, 0, 1, 0);
    idle(6, 0, 1);
    idle(3, 1, 1);

    for (int c = 0; c < 3000; c++) begin
      r = $urandom_range(0, 9);
      if (r < 3) rop = 6'(10 + $urandom_range(0, 3));
      else if (r == 3) rop = 6'(14 + $urandom_range(0, 3));
      else if (r == 4) rop = 6'(18 + $urandom_range(0, 1));
      else rop = 6'($urandom_range(0, 63));
      step(1'($urandom_range(0, 1)), rop, $urandom_range(0, 3) != 0,
           $urandom_range(0, 2) != 0, $urandom_range(0, 49) == 0);
    end
    idle(40, 1, 1);

    // Asynchronous reset in the middle of a multiply.
    step(1, OpMul, 1, 1, 0);
    step(0, OpAdd, 1, 1, 0);
    chk("pre_reset_aktif", 32'(amb_aktif_o), 32'd1);
    #2;
    rst_ni = 1'b0;
    #1;
    chk("async_aktif", 32'(amb_aktif_o), 32'd0);
    chk("async_gecerli", 32'(sonuc_gecerli_o), 32'd0);
    chk("async_dallanma", 32'(dallanma_o), 32'd0);
    chk("async_kod", 32'(amb_islem_kodu_o), 32'd0);
    chk("async_hazir", 32'(buyruk_hazir_o), 32'd1);
    @(posedge clk_i);
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    idle(4, 1, 1);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
